neuron_core_wb_front: RTL

Wishbone classic slave front-end for the 256x256 neuron core. It accepts single-beat transactions from the Caravel management bus and checks the upper-address window. It splits the core offset into a region (synapse matrix / parameter file / spike-out), launches one request pulse to the selected target, and waits for the target's acknowledge or a timeout. It then returns exactly one `wbs_ack_o` (or `wbs_err_o`) per transaction.

---
 rtl/neuron_core_pkg.sv | 21 ++
 rtl/nc_region_decode.sv | 22 ++
 rtl/neuron_core_wb_front.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/neuron_core_pkg.sv
// neuron_core_pkg: shared definitions for the neuron core Wishbone front-end.
//   - NC_REGION_*      : 2-bit region codes taken from wbs_adr_i[14:13]
//   - nc_wb_state_t    : front-end FSM state encoding
//   - NC_WB_TIMEOUT_DEF: default number of cycles to wait for a target acknowledge
package neuron_core_pkg;

    localparam logic [1:0] NC_REGION_SYNAP = 2'b00;
    localparam logic [1:0] NC_REGION_PARAM = 2'b01;
    localparam logic [1:0] NC_REGION_SPIKE = 2'b10;
    localparam logic [1:0] NC_REGION_NONE  = 2'b11;

    localparam int unsigned NC_WB_TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StResp
    } nc_wb_state_t;

endpackage

// File: rtl/nc_region_decode.sv
// nc_region_decode: combinational address decode for the neuron core window.
//   adr_i    : Wishbone byte address
//   region_o : region code (synapse / parameter / spike-out / none)
//   mapped_o : address is inside the BASE_HI window and the region is populated
module nc_region_decode
    import neuron_core_pkg::*;
#(
    parameter logic [15:0] BASE_HI = 16'h3000
) (
    input  logic [31:0] adr_i,
    output logic [1:0]  region_o,
    output logic        mapped_o
);

    // Bits below the region field are consumed by the top, not by the decode.
    logic unused_adr;
    assign unused_adr = ^{adr_i[15], adr_i[12:0]};

    assign region_o = adr_i[14:13];
    assign mapped_o = (adr_i[31:16] == BASE_HI) && (adr_i[14:13] != NC_REGION_NONE);

endmodule

// File: rtl/neuron_core_wb_front.sv
// neuron_core_wb_front: Wishbone classic slave front-end for the neuron core.
// Accepts one single-beat transaction at a time, issues a one-cycle request pulse
// to the addressed target, and returns exactly one ack (or err) per transaction.
//
// Ports:
//   wb_clk_i, wb_rst_n       : clock, asynchronous active-low reset
//   wbs_cyc_i/stb_i/we_i     : Wishbone cycle, strobe, write enable
//   wbs_sel_i, wbs_adr_i,
//   wbs_dat_i                : byte selects, byte address, write data
//   wbs_ack_o, wbs_err_o     : response (err only used when NC_WB_ERR_EN is defined)
//   wbs_dat_o                : read data, zero outside the ack cycle
//   core_addr_o/wdata_o/
//   sel_o/we_o, param_num_o  : transaction fields latched at acceptance
//   synap/param/spike_req_o  : one-cycle request pulses, mutually exclusive
//   core_ack_i, core_rdata_i : target completion and read data
//
// Configuration macro: NC_WB_ERR_EN -- when defined, faults (unmapped address or
// timeout) respond on wbs_err_o; otherwise they respond with wbs_ack_o and zero data.
module neuron_core_wb_front
    import neuron_core_pkg::*;
#(
    parameter logic [15:0] BASE_HI     = 16'h3000,
    parameter int unsigned TIMEOUT_CYC = NC_WB_TIMEOUT_DEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic [31:0] wbs_dat_o,
    output logic [12:0] core_addr_o,
    output logic [31:0] core_wdata_o,
    output logic [3:0]  core_sel_o,
    output logic        core_we_o,
    output logic [7:0]  param_num_o,
    output logic        synap_req_o,
    output logic        param_req_o,
    output logic        spike_req_o,
    input  logic        core_ack_i,
    input  logic [31:0] core_rdata_i
);

`ifdef NC_WB_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    localparam logic [7:0] TimeoutVal = 8'(TIMEOUT_CYC);

    logic [1:0] region;
    logic       mapped;

    nc_region_decode #(
        .BASE_HI (BASE_HI)
    ) u_decode (
        .adr_i    (wbs_adr_i),
        .region_o (region),
        .mapped_o (mapped)
    );

    nc_wb_state_t state_q;
    logic [7:0]   cnt_q;
    logic         hold_q;     // blocks acceptance in the cycle right after a response
    logic         ack_q;
    logic         err_q;
    logic [31:0]  dat_q;
    logic [12:0]  addr_q;
    logic [31:0]  wdata_q;
    logic [3:0]   sel_q;
    logic         we_q;
    logic [7:0]   pnum_q;
    logic         synap_req_q;
    logic         param_req_q;
    logic         spike_req_q;

    // All outputs are registered; the response is computed on entry to StResp so
    // that ack/err and data appear together in the StResp cycle.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            hold_q      <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            dat_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            pnum_q      <= '0;
            synap_req_q <= 1'b0;
            param_req_q <= 1'b0;
            spike_req_q <= 1'b0;
        end else begin
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            dat_q       <= '0;
            synap_req_q <= 1'b0;
            param_req_q <= 1'b0;
            spike_req_q <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    hold_q <= 1'b0;
                    if (wbs_cyc_i && wbs_stb_i && !hold_q) begin
                        addr_q  <= wbs_adr_i[12:0];
                        wdata_q <= wbs_dat_i;
                        sel_q   <= wbs_sel_i;
                        we_q    <= wbs_we_i;
                        pnum_q  <= wbs_adr_i[11:4];
                        if (mapped) begin
                            state_q     <= StReq;
                            synap_req_q <= (region == NC_REGION_SYNAP);
                            param_req_q <= (region == NC_REGION_PARAM);
                            spike_req_q <= (region == NC_REGION_SPIKE);
                        end else begin
                            state_q <= StResp;
                            if (ErrEn) err_q <= 1'b1;
                            else       ack_q <= 1'b1;
                        end
                    end
                end

                StReq: begin
                    cnt_q <= '0;
                    if (!wbs_cyc_i) begin
                        state_q <= StIdle;
                    end else if (core_ack_i) begin
                        state_q <= StResp;
                        ack_q   <= 1'b1;
                        dat_q   <= we_q ? 32'h0 : core_rdata_i;
                    end else begin
                        state_q <= StWait;
                    end
                end

                StWait: begin
                    // Target ack wins over a timeout landing in the same cycle.
                    if (!wbs_cyc_i) begin
                        state_q <= StIdle;
                    end else if (core_ack_i) begin
                        state_q <= StResp;
                        ack_q   <= 1'b1;
                        dat_q   <= we_q ? 32'h0 : core_rdata_i;
                    end else if (cnt_q == TimeoutVal) begin
                        state_q <= StResp;
                        if (ErrEn) err_q <= 1'b1;
                        else       ack_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end

                StResp: begin
                    state_q <= StIdle;
                    hold_q  <= 1'b1;
                end

                default: state_q <= StIdle;
            endcase
        end
    end

    assign wbs_ack_o    = ack_q;
    assign wbs_err_o    = ErrEn & err_q;
    assign wbs_dat_o    = dat_q;
    assign core_addr_o  = addr_q;
    assign core_wdata_o = wdata_q;
    assign core_sel_o   = sel_q;
    assign core_we_o    = we_q;
    assign param_num_o  = pnum_q;
    assign synap_req_o  = synap_req_q;
    assign param_req_o  = param_req_q;
    assign spike_req_o  = spike_req_q;

endmodule
